// File: rtl/data_memory_mp.sv
// Parametrised multi-port data memory: registered reads with optional write bypass,
// highest-port-wins write conflicts, post-reset clear sequencer and out-of-range error capture.
module data_memory_mp #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int RD_PORTS  = 4,
  parameter int WR_PORTS  = 4,
  parameter int RD_BYPASS = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [RD_PORTS-1:0]          rd_en,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  output logic [RD_PORTS-1:0]          rd_valid,
  input  logic [WR_PORTS-1:0]          wr_en,
  input  logic [WR_PORTS*ADDR_W-1:0]   wr_addr,
  input  logic [WR_PORTS*DATA_W-1:0]   wr_data,
  output logic                         busy,
  output logic                         err,
  input  logic                         err_clear,
  output logic [ADDR_W-1:0]            err_addr
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                      state_q;
  logic [IDX_W-1:0]            clear_ptr_q;
  logic [RD_PORTS*DATA_W-1:0]  rd_data_q;
  logic [RD_PORTS-1:0]         rd_valid_q;
  logic                        err_q;
  logic [ADDR_W-1:0]           err_addr_q;

  logic [DATA_W-1:0]           mem [DEPTH];

  logic [ADDR_W-1:0]           ra [RD_PORTS];
  logic [ADDR_W-1:0]           wa [WR_PORTS];
  logic [DATA_W-1:0]           wd [WR_PORTS];
  logic [RD_PORTS-1:0]         rd_in;
  logic [WR_PORTS-1:0]         wr_in;
  logic [RD_PORTS*DATA_W-1:0]  rd_word_d;

  logic                        err_hit_d;
  logic [ADDR_W-1:0]           err_hit_addr_d;

  genvar gi;
  generate
    for (gi = 0; gi < WR_PORTS; gi++) begin : g_wr
      assign wa[gi]    = wr_addr[gi*ADDR_W +: ADDR_W];
      assign wd[gi]    = wr_data[gi*DATA_W +: DATA_W];
      assign wr_in[gi] = ({1'b0, wa[gi]} < DEPTH_L);
    end

    for (gi = 0; gi < RD_PORTS; gi++) begin : g_rd
      logic              hit;
      logic [DATA_W-1:0] hit_data;

      assign ra[gi]    = rd_addr[gi*ADDR_W +: ADDR_W];
      assign rd_in[gi] = ({1'b0, ra[gi]} < DEPTH_L);

      // Ascending scan so the highest-numbered matching write port is the one forwarded.
      always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int j = 0; j < WR_PORTS; j++) begin
          if (wr_en[j] && wr_in[j] && (wa[j] == ra[gi])) begin
            hit      = 1'b1;
            hit_data = wd[j];
          end
        end
      end

      assign rd_word_d[gi*DATA_W +: DATA_W] =
          !rd_in[gi]                  ? '0 :
          ((RD_BYPASS != 0) && hit)   ? hit_data :
                                        mem[ra[gi][IDX_W-1:0]];
    end
  endgenerate

  // First offender wins: read ports in ascending order, then write ports.
  always_comb begin
    err_hit_d      = 1'b0;
    err_hit_addr_d = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      if (!err_hit_d && rd_en[i] && !rd_in[i]) begin
        err_hit_d      = 1'b1;
        err_hit_addr_d = ra[i];
      end
    end
    for (int j = 0; j < WR_PORTS; j++) begin
      if (!err_hit_d && wr_en[j] && !wr_in[j]) begin
        err_hit_d      = 1'b1;
        err_hit_addr_d = wa[j];
      end
    end
  end

  // Array storage has no reset; later loop iterations override earlier ones on conflicts.
  always_ff @(posedge clock) begin
    if (state_q == ST_CLEAR) begin
      mem[clear_ptr_q] <= '0;
    end else if (reset) begin
      for (int j = 0; j < WR_PORTS; j++) begin
        if (wr_en[j] && wr_in[j]) begin
          mem[wa[j][IDX_W-1:0]] <= wd[j];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_CLEAR;
      clear_ptr_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= '0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          rd_valid_q  <= '0;
          clear_ptr_q <= clear_ptr_q + 1'b1;
          if (clear_ptr_q == LAST_IDX) begin
            state_q <= ST_READY;
          end
        end
        default: begin
          rd_valid_q <= rd_en;
          for (int i = 0; i < RD_PORTS; i++) begin
            if (rd_en[i]) begin
              rd_data_q[i*DATA_W +: DATA_W] <= rd_word_d[i*DATA_W +: DATA_W];
            end
          end
          if (err_hit_d) begin
            err_q <= 1'b1;
            if (!err_q || err_clear) begin
              err_addr_q <= err_hit_addr_d;
            end
          end else if (err_clear) begin
            err_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == ST_CLEAR);
  assign err      = err_q;
  assign err_addr = err_addr_q;

endmodule

// File: doc/data_memory_mp.md
Name: data_memory_mp

Overview:
Parametrised multi-port data memory that succeeds the fixed 8-bit, 4R/4W data store in the AAP FPGA pipeline. Widths, depth and read/write port counts are set by parameters. Reads are registered with optional write-to-read bypass, and same-address write conflicts follow a defined priority. A post-reset clear sequencer zeroes the array, and out-of-range accesses are flagged.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 8, address width in bits
DEPTH, 256, number of words; must satisfy DEPTH <= 2**ADDR_W
RD_PORTS, 4, number of read ports
WR_PORTS, 4, number of write ports
RD_BYPASS, 1, 1 = a read returns same-cycle write data; 0 = a read returns pre-write data

Ports:
clock  input  1  single clock; all state updates on the rising edge
reset  input  1  synchronous, active-low reset
rd_en  input  RD_PORTS  per-port read enable
rd_addr  input  RD_PORTS*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
rd_data  output  RD_PORTS*DATA_W  packed registered read data
rd_valid  output  RD_PORTS  per-port pulse, high in the cycle rd_data is updated
wr_en  input  WR_PORTS  per-port write enable
wr_addr  input  WR_PORTS*ADDR_W  packed write addresses
wr_data  input  WR_PORTS*DATA_W  packed write data
busy  output  1  high while the clear sequence runs; all accesses are ignored while high
err  output  1  sticky out-of-range access flag
err_clear  input  1  clears err
err_addr  output  ADDR_W  address of the first out-of-range access since err was last cleared

Behaviour:
- Reset: if reset==0 at a rising edge, the block enters CLEAR and sets clear_ptr=0, busy=1, rd_data=0, rd_valid=0, err=0, err_addr=0. The array contents are not guaranteed until CLEAR finishes.
- States: CLEAR and READY.
  - CLEAR: each cycle writes 0 to mem[clear_ptr] and increments clear_ptr. The cycle that clears DEPTH-1 moves the block to READY, so busy=1 for exactly DEPTH cycles after reset is released.
  - READY: normal operation. The block leaves READY only on reset.
- Reset asserted mid-CLEAR restarts the clear from address 0.
- During CLEAR: wr_en and rd_en are ignored, rd_valid=0, rd_data holds 0, and err does not update.
- Write, in READY: on the rising edge, every port j with wr_en[j]=1 and wr_addr_j < DEPTH writes mem[wr_addr_j] = wr_data_j.
- Write conflicts: if several enabled ports target the same address, the highest-numbered port wins.
- Out-of-range write (addr >= DEPTH): dropped with no array change, and sets err.
- Read latency is 1 cycle. If rd_en[i]=1 at edge t, then after edge t:
  - rd_data_i = mem[rd_addr_i];
  - rd_valid[i]=1 for one cycle.
- If rd_en[i]=0, rd_data_i holds its previous value and rd_valid[i]=0.
- Read/write collision, same edge and same address:
  - RD_BYPASS=1: rd_data returns the winning write data.
  - RD_BYPASS=0: rd_data returns the value before the write.
- Out-of-range read: rd_data_i=0, rd_valid[i]=1, and sets err.
- err and err_addr:
  - err is sticky.
  - err_addr captures the lowest-numbered offending port's address, read ports before write ports, only when err was 0.
  - err_clear=1 clears err at the edge.
  - A new error in the same cycle as err_clear wins: err=1 and err_addr is captured.
- Multiple read ports may read the same address in the same cycle; all of them return the same data.
- Reads and writes to different addresses in the same cycle are fully independent.

Test Plan:
- Reset then CLEAR, DEPTH=256 → busy=1 for 256 cycles after reset goes to 1. Then read addresses 0, 85, 170 and 255 on ports 0-3 → all rd_data=0 and rd_valid=4'b1111 one cycle later.
- Write conflict: in one cycle, wr ports 0-3 all target 0x10 with data 0x11/0x22/0x33/0x44 → a read of 0x10 returns 0x44. Ports 1 and 2 writing 0x20 and 0x21 with 0xAA and 0xBB land independently.
- Bypass: write 0x5A to 0x30 while port 0 reads 0x30 in the same cycle, where 0x30 previously held 0x01 → rd_data_0=0x5A with RD_BYPASS=1 and 0x01 with RD_BYPASS=0.
- Out-of-range, DEPTH=128: port 2 reads 200 → rd_data_2=0, err=1, err_addr=200. A later write to 150 leaves err_addr=200. After err_clear, a write to 129 gives err_addr=129, and the array is unchanged.
- Reset mid-CLEAR: release reset, reassert it at cycle 50, then release again → busy stays high for a full DEPTH cycles from the second release. Accesses attempted while busy have no effect and give rd_valid=0.
- Hold behaviour: read 0x05 (0x77), then hold rd_en=0 for 3 cycles while 0x05 is written with 0x99 → rd_data_0 stays 0x77 and rd_valid=0 until the next read, which returns 0x99.
